mem_burst_unit: RTL and testbench

- Parametrised multicycle load/store sequencer for the execute stage; generalises the single-cycle store, two-cycle load, and pair load/store paths to a burst of 1..MAX_BURST consecutive words and registers.
- Owns the data-memory read/write ports and the register write port during a burst.
- Drives the front-end stall and a completion pulse.
- Forwards a pending register writeback into store data.

---
 rtl/mem_burst_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_burst_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_unit.sv
// Multicycle load/store burst sequencer for the execute stage (1..MAX_BURST words).
// Optional macro MEM_BURST_WRAP_CHECK_EN: reject bursts that would run past the top address.
module mem_burst_unit #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 15,
    parameter int REG_W     = 4,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_is_store,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [REG_W-1:0]  i_first_reg,
    input  logic [CNT_W-1:0]  i_count,
    input  logic              i_fwd_wen,
    input  logic [REG_W-1:0]  i_fwd_waddr,
    input  logic [DATA_W-1:0] i_fwd_wdata,
    output logic [ADDR_W-1:0] o_mem_raddr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [REG_W-1:0]  o_reg_raddr,
    input  logic [DATA_W-1:0] i_reg_rdata,
    output logic              o_reg_wen,
    output logic [REG_W-1:0]  o_reg_waddr,
    output logic [DATA_W-1:0] o_reg_wdata,
    output logic              o_busy,
    output logic              o_stall,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE
    } state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_idx, w_idx_next;
    logic [CNT_W-1:0]  r_n, w_n_next;
    logic [ADDR_W-1:0] r_base, w_base_next;
    logic [REG_W-1:0]  r_first, w_first_next;
    logic              r_busy;

    logic [CNT_W-1:0]  w_eff;
    logic [CNT_W-1:0]  w_last;
    logic [ADDR_W-1:0] w_addr_k;
    logic [REG_W-1:0]  w_reg_k;
    logic [REG_W-1:0]  w_load_reg;
    logic [DATA_W-1:0] w_store_data;
    logic              w_reject;

    assign w_eff  = (i_count > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : i_count;
    assign w_last = r_n - CNT_W'(1);

    // The acceptance cycle runs from the live inputs; later cycles from the captured burst.
    assign w_addr_k   = (r_state == ST_IDLE) ? i_base_addr : r_base + ADDR_W'(r_idx);
    assign w_reg_k    = (r_state == ST_IDLE) ? i_first_reg : r_first + REG_W'(r_idx);
    assign w_load_reg = r_first + REG_W'(r_idx) - REG_W'(1);

    assign w_store_data = (i_fwd_wen && (i_fwd_waddr == w_reg_k)) ? i_fwd_wdata : i_reg_rdata;

`ifdef MEM_BURST_WRAP_CHECK_EN
    logic [ADDR_W:0] w_end_excl;
    assign w_end_excl = {1'b0, i_base_addr} + (ADDR_W + 1)'(w_eff);
    assign w_reject   = w_end_excl[ADDR_W] && (w_end_excl[ADDR_W-1:0] != '0);
`else
    assign w_reject = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        w_idx_next   = r_idx;
        w_n_next     = r_n;
        w_base_next  = r_base;
        w_first_next = r_first;
        o_mem_raddr  = w_addr_k;
        o_mem_wen    = 1'b0;
        o_mem_waddr  = w_addr_k;
        o_mem_wdata  = w_store_data;
        o_reg_raddr  = w_reg_k;
        o_reg_wen    = 1'b0;
        o_reg_waddr  = w_load_reg;
        o_reg_wdata  = i_mem_rdata;
        o_stall      = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_rst) begin
                    if (w_reject) begin
                        o_err = 1'b1;
                    end else if (w_eff == '0) begin
                        o_done = 1'b1;
                    end else begin
                        w_base_next  = i_base_addr;
                        w_first_next = i_first_reg;
                        w_n_next     = w_eff;
                        if (!i_is_store) begin
                            o_stall    = 1'b1;
                            w_next     = ST_LOAD;
                            w_idx_next = CNT_W'(1);
                        end else begin
                            o_mem_wen = 1'b1;
                            // A single-word store finishes in the acceptance cycle.
                            if (w_eff == CNT_W'(1)) begin
                                o_done = 1'b1;
                            end else begin
                                o_stall    = 1'b1;
                                w_next     = ST_STORE;
                                w_idx_next = CNT_W'(1);
                            end
                        end
                    end
                end
            end
            ST_LOAD: begin
                o_reg_wen = 1'b1;
                if (r_idx == r_n) begin
                    o_done     = 1'b1;
                    w_next     = ST_IDLE;
                    w_idx_next = '0;
                end else begin
                    o_stall    = 1'b1;
                    w_idx_next = r_idx + CNT_W'(1);
                end
            end
            ST_STORE: begin
                o_mem_wen = 1'b1;
                if (r_idx == w_last) begin
                    o_done     = 1'b1;
                    w_next     = ST_IDLE;
                    w_idx_next = '0;
                end else begin
                    o_stall    = 1'b1;
                    w_idx_next = r_idx + CNT_W'(1);
                end
            end
            default: begin
                w_next     = ST_IDLE;
                w_idx_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_n     <= '0;
            r_base  <= '0;
            r_first <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_n     <= w_n_next;
            r_base  <= w_base_next;
            r_first <= w_first_next;
            r_busy  <= (w_next != ST_IDLE);
        end
    end

    assign o_busy = r_busy;

endmodule

// File: tb/tb_mem_burst_unit.sv
// Self-checking bench for mem_burst_unit: burst-level reference model plus directed literal checks.
// Honours MEM_BURST_WRAP_CHECK_EN the same way as the design.
module tb_mem_burst_unit;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 15;
    localparam int REG_W     = 4;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 3;
    localparam int MEM_WORDS = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic              isStore;
    logic [ADDR_W-1:0] baseAddr;
    logic [REG_W-1:0]  firstReg;
    logic [CNT_W-1:0]  count;
    logic              fwdWen;
    logic [REG_W-1:0]  fwdWaddr;
    logic [DATA_W-1:0] fwdWdata;
    logic [ADDR_W-1:0] memRaddr;
    logic [DATA_W-1:0] memRdata;
    logic              memWen;
    logic [ADDR_W-1:0] memWaddr;
    logic [DATA_W-1:0] memWdata;
    logic [REG_W-1:0]  regRaddr;
    logic [DATA_W-1:0] regRdata;
    logic              regWen;
    logic [REG_W-1:0]  regWaddr;
    logic [DATA_W-1:0] regWdata;
    logic              busy;
    logic              stall;
    logic              done;
    logic              err;

    mem_burst_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_is_store(isStore),
        .i_base_addr(baseAddr), .i_first_reg(firstReg), .i_count(count),
        .i_fwd_wen(fwdWen), .i_fwd_waddr(fwdWaddr), .i_fwd_wdata(fwdWdata),
        .o_mem_raddr(memRaddr), .i_mem_rdata(memRdata),
        .o_mem_wen(memWen), .o_mem_waddr(memWaddr), .o_mem_wdata(memWdata),
        .o_reg_raddr(regRaddr), .i_reg_rdata(regRdata),
        .o_reg_wen(regWen), .o_reg_waddr(regWaddr), .o_reg_wdata(regWdata),
        .o_busy(busy), .o_stall(stall), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    // Environment: data memory with one-cycle read latency, register file, and preload pokes.
    logic [DATA_W-1:0] mem  [0:MEM_WORDS-1];
    logic [DATA_W-1:0] regs [0:15];
    logic              envLoad;
    logic              pokeMemEn;
    logic [ADDR_W-1:0] pokeMemAddr;
    logic [DATA_W-1:0] pokeMemData;
    logic              pokeRegEn;
    logic [REG_W-1:0]  pokeRegAddr;
    logic [DATA_W-1:0] pokeRegData;

    always @(posedge clk) begin
        if (envLoad) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= DATA_W'(i * 40503 + 4951);
            for (int r = 0; r < 16; r++) regs[r] <= DATA_W'(r * 4369 + 7);
        end else begin
            if (memWen) mem[memWaddr] <= memWdata;
            if (regWen) regs[regWaddr] <= regWdata;
            if (pokeMemEn) mem[pokeMemAddr] <= pokeMemData;
            if (pokeRegEn) regs[pokeRegAddr] <= pokeRegData;
        end
        memRdata <= mem[memRaddr];
    end

    assign regRdata = regs[regRaddr];

    int nCompared;
    int nMismatch;
    int cntStall, cntRegWen, cntMemWen, cntDone, cntErr;
    bit randFwd;

    // Reference model state: one active burst described by its parameters and cycle number.
    bit mActive;
    bit mStore;
    int mBase, mFirst, mN, mK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic evalCycle();
        bit eStall, eBusy, eDone, eErr, eMemWen, eRegWen, chkRaddr, chkRegRaddr;
        logic [ADDR_W-1:0] expRaddr, expMemWaddr;
        logic [DATA_W-1:0] expMemWdata, expRegWdata;
        logic [REG_W-1:0]  expRegRaddr, expRegWaddr;
        int n;
        bit over;
        eStall = 0; eBusy = 0; eDone = 0; eErr = 0; eMemWen = 0; eRegWen = 0;
        chkRaddr = 0; chkRegRaddr = 0;
        expRaddr = '0; expMemWaddr = '0; expMemWdata = '0; expRegWdata = '0;
        expRegRaddr = '0; expRegWaddr = '0;
        if (!mActive) begin
            if (start) begin
                n = (int'(count) > MAX_BURST) ? MAX_BURST : int'(count);
                over = (n > 0) && (int'(baseAddr) + n - 1 > MEM_WORDS - 1);
`ifdef MEM_BURST_WRAP_CHECK_EN
                if (over) eErr = 1;
                else
`else
                if (over) n = n;
`endif
                if (n == 0) begin
                    eDone = 1;
                end else if (!isStore) begin
                    chkRaddr = 1; expRaddr = baseAddr; eStall = 1;
                    mActive = 1; mStore = 0; mBase = int'(baseAddr); mFirst = int'(firstReg); mN = n; mK = 1;
                end else begin
                    eMemWen = 1; expMemWaddr = baseAddr; chkRegRaddr = 1; expRegRaddr = firstReg;
                    expMemWdata = (fwdWen && fwdWaddr == firstReg) ? fwdWdata : regs[firstReg];
                    eStall = (n > 1); eDone = (n == 1);
                    if (n > 1) begin
                        mActive = 1; mStore = 1; mBase = int'(baseAddr); mFirst = int'(firstReg); mN = n; mK = 1;
                    end
                end
            end
        end else begin
            eBusy = 1;
            if (!mStore) begin
                eRegWen = 1;
                expRegWaddr = REG_W'(mFirst + mK - 1);
                expRegWdata = mem[ADDR_W'(mBase + mK - 1)];
                if (mK < mN) begin
                    chkRaddr = 1; expRaddr = ADDR_W'(mBase + mK); eStall = 1; mK++;
                end else begin
                    eDone = 1; mActive = 0;
                end
            end else begin
                eMemWen = 1; expMemWaddr = ADDR_W'(mBase + mK);
                chkRegRaddr = 1; expRegRaddr = REG_W'(mFirst + mK);
                expMemWdata = (fwdWen && fwdWaddr == expRegRaddr) ? fwdWdata : regs[expRegRaddr];
                if (mK < mN - 1) begin
                    eStall = 1; mK++;
                end else begin
                    eDone = 1; mActive = 0;
                end
            end
        end
        checkOutput("stall", 32'(stall), 32'(eStall));
        checkOutput("busy", 32'(busy), 32'(eBusy));
        checkOutput("done", 32'(done), 32'(eDone));
        checkOutput("err", 32'(err), 32'(eErr));
        checkOutput("mem_wen", 32'(memWen), 32'(eMemWen));
        checkOutput("reg_wen", 32'(regWen), 32'(eRegWen));
        if (chkRaddr) checkOutput("mem_raddr", 32'(memRaddr), 32'(expRaddr));
        if (chkRegRaddr) checkOutput("reg_raddr", 32'(regRaddr), 32'(expRegRaddr));
        if (eMemWen && memWen) begin
            checkOutput("mem_waddr", 32'(memWaddr), 32'(expMemWaddr));
            checkOutput("mem_wdata", 32'(memWdata), 32'(expMemWdata));
        end
        if (eRegWen && regWen) begin
            checkOutput("reg_waddr", 32'(regWaddr), 32'(expRegWaddr));
            checkOutput("reg_wdata", 32'(regWdata), 32'(expRegWdata));
        end
        cntStall  += int'(stall);
        cntRegWen += int'(regWen);
        cntMemWen += int'(memWen);
        cntDone   += int'(done);
        cntErr    += int'(err);
    endtask

    task automatic monitorLoop();
        forever begin
            @(negedge clk);
            if (rst) mActive = 0;
            else evalCycle();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (randFwd) begin
            fwdWen   = 1'($urandom);
            fwdWaddr = REG_W'($urandom);
            fwdWdata = DATA_W'($urandom);
        end
    endtask

    task automatic pokeMem(input int a, input int d);
        pokeMemEn = 1; pokeMemAddr = ADDR_W'(a); pokeMemData = DATA_W'(d);
        step();
        pokeMemEn = 0;
    endtask

    task automatic pokeReg(input int a, input int d);
        pokeRegEn = 1; pokeRegAddr = REG_W'(a); pokeRegData = DATA_W'(d);
        step();
        pokeRegEn = 0;
    endtask

    task automatic applyStimulus(input bit st, input int b, input int f, input int c);
        start = 1; isStore = st; baseAddr = ADDR_W'(b); firstReg = REG_W'(f); count = CNT_W'(c);
        step();
        start = 0;
    endtask

    task automatic waitIdle();
        int i;
        i = 0;
        while (busy && i < 20) begin
            step();
            i++;
        end
        if (i >= 20) checkOutput("idle timeout", 32'd1, 32'd0);
        step();
    endtask

    int sStall, sRegWen, sMemWen, sDone, sErr;

    task automatic snap();
        sStall = cntStall; sRegWen = cntRegWen; sMemWen = cntMemWen; sDone = cntDone; sErr = cntErr;
    endtask

    initial begin
        clk = 0; rst = 1; start = 0; isStore = 0; baseAddr = '0; firstReg = '0; count = '0;
        fwdWen = 0; fwdWaddr = '0; fwdWdata = '0;
        envLoad = 1; pokeMemEn = 0; pokeMemAddr = '0; pokeMemData = '0;
        pokeRegEn = 0; pokeRegAddr = '0; pokeRegData = '0;
        nCompared = 0; nMismatch = 0; randFwd = 0; mActive = 0; mStore = 0;
        mBase = 0; mFirst = 0; mN = 0; mK = 0;
        cntStall = 0; cntRegWen = 0; cntMemWen = 0; cntDone = 0; cntErr = 0;
        fork
            monitorLoop();
        join_none
        step();
        envLoad = 0;
        step();
        step();
        rst = 0;
        step();
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);

        // Load N=3 from 0x10 into R4..R6
        pokeMem('h10, 'hAAAA); pokeMem('h11, 'hBBBB); pokeMem('h12, 'hCCCC);
        snap();
        applyStimulus(0, 'h10, 4, 3);
        waitIdle();
        checkOutput("load3 R4", 32'(regs[4]), 32'hAAAA);
        checkOutput("load3 R5", 32'(regs[5]), 32'hBBBB);
        checkOutput("load3 R6", 32'(regs[6]), 32'hCCCC);
        checkOutput("load3 stalls", 32'(cntStall - sStall), 32'd3);
        checkOutput("load3 done", 32'(cntDone - sDone), 32'd1);

        // Store N=2 from R14 with a forwarded R15 in cycle 1
        pokeReg(14, 'h1234); pokeReg(15, 'h5678);
        snap();
        start = 1; isStore = 1; baseAddr = ADDR_W'('h20); firstReg = 4'd14; count = 3'd2;
        step();
        start = 0; fwdWen = 1; fwdWaddr = 4'd15; fwdWdata = 16'h9999;
        step();
        fwdWen = 0;
        waitIdle();
        checkOutput("store2 m20", 32'(mem['h20]), 32'h1234);
        checkOutput("store2 m21", 32'(mem['h21]), 32'h9999);
        checkOutput("store2 stalls", 32'(cntStall - sStall), 32'd1);
        checkOutput("store2 writes", 32'(cntMemWen - sMemWen), 32'd2);

        // Register index wraps R15 -> R0
        pokeMem('h100, 'h1111); pokeMem('h101, 'h2222);
        applyStimulus(0, 'h100, 15, 2);
        waitIdle();
        checkOutput("regwrap R15", 32'(regs[15]), 32'h1111);
        checkOutput("regwrap R0", 32'(regs[0]), 32'h2222);

        // count=0, then count=7 clamped to 4
        snap();
        applyStimulus(0, 'h200, 1, 0);
        waitIdle();
        checkOutput("cnt0 done", 32'(cntDone - sDone), 32'd1);
        checkOutput("cnt0 access", 32'(cntRegWen - sRegWen + cntMemWen - sMemWen + cntStall - sStall), 32'd0);
        snap();
        applyStimulus(1, 'h300, 3, 7);
        waitIdle();
        checkOutput("cnt7 writes", 32'(cntMemWen - sMemWen), 32'd4);

        // start held through a load N=4, second burst cut by reset in its cycle 2
        snap();
        start = 1; isStore = 0; baseAddr = ADDR_W'('h400); firstReg = 4'd2; count = 3'd4;
        repeat (6) step();
        start = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        checkOutput("held done", 32'(cntDone - sDone), 32'd1);
        checkOutput("held regwen", 32'(cntRegWen - sRegWen), 32'd5);
        checkOutput("held stalls", 32'(cntStall - sStall), 32'd6);
        checkOutput("rst busy", 32'(busy), 32'd0);
        snap();
        repeat (4) step();
        checkOutput("rst quiet", 32'(cntRegWen - sRegWen + cntStall - sStall), 32'd0);

        // Burst crossing the top of the address space
        pokeMem('h7FFE, 'hA1); pokeMem('h7FFF, 'hA2); pokeMem('h0, 'hA3); pokeMem('h1, 'hA4);
        snap();
        applyStimulus(0, 'h7FFE, 8, 4);
        waitIdle();
`ifdef MEM_BURST_WRAP_CHECK_EN
        checkOutput("wrap err", 32'(cntErr - sErr), 32'd1);
        checkOutput("wrap regwen", 32'(cntRegWen - sRegWen), 32'd0);
        checkOutput("wrap done", 32'(cntDone - sDone), 32'd0);
`else
        checkOutput("wrap R8", 32'(regs[8]), 32'hA1);
        checkOutput("wrap R9", 32'(regs[9]), 32'hA2);
        checkOutput("wrap R10", 32'(regs[10]), 32'hA3);
        checkOutput("wrap R11", 32'(regs[11]), 32'hA4);
        checkOutput("wrap err", 32'(cntErr - sErr), 32'd0);
`endif

        // Randomized traffic with forwarding noise and occasional resets
        randFwd = 1;
        for (int c = 0; c < 1500; c++) begin
            rst      = ($urandom % 64 == 0);
            start    = ($urandom % 3 == 0);
            isStore  = 1'($urandom);
            baseAddr = ($urandom % 4 == 0) ? ADDR_W'(32'h7FFC + $urandom % 4) : ADDR_W'($urandom);
            firstReg = REG_W'($urandom);
            count    = CNT_W'($urandom);
            step();
        end
        rst = 0; start = 0; randFwd = 0; fwdWen = 0;
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
